// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame geometry and the
// byte shifted out when the slave has nothing queued.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;

  localparam logic [SPI_DATA_WIDTH-1:0] SPI_UNDERRUN_FILL = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous level, with single-cycle rise/fall
// pulses that line up with the synchronized level output.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: flops use non-blocking assignments so every stage samples the value
  // its neighbour held before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Pulses are combinational so the consumer acts on the edge STAGES+1 cycles
  // after the raw transition.
  assign o_level = r_sync[STAGES-1];
  assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (CPOL=0, CPHA=0, LSB-first) in the system clock domain with a
// one-deep tx holding register. Define SPI_SLAVE_TRISTATE_EN to float MISO when idle.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txLoad,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  output logic                  busy
);

  localparam int                   CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] FILL    = DATA_WIDTH'(SPI_UNDERRUN_FILL);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_async(SCLK),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // CS resets high so leaving reset never looks like a select.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .i_async(CS),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_async(MOSI),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  spi_state_e              r_state, w_next_state;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_rx_shift, r_tx_shift, r_hold, r_rx_data;
  logic                    r_hold_full, r_rx_valid, r_byte_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assigned first so every path drives w_next_state; a missing
  // branch would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next_state = SHIFT;
      SHIFT:   if (w_cs_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  logic                  w_start, w_stop, w_sample, w_advance, w_reload;
  logic                  w_consume, w_load_accept, w_cs_unused;
  logic [DATA_WIDTH-1:0] w_next_tx, w_rx_next;

  assign w_start       = (r_state == IDLE)  && w_cs_fall;
  assign w_stop        = (r_state == SHIFT) && w_cs_rise;
  assign w_sample      = (r_state == SHIFT) && !w_cs_rise && w_sclk_rise;
  assign w_advance     = (r_state == SHIFT) && !w_cs_rise && w_sclk_fall;
  assign w_reload      = w_advance && r_byte_done;
  assign w_consume     = w_start || w_reload;
  assign w_load_accept = txLoad && !r_hold_full;
  // No bypass: a byte accepted this cycle is not visible to a same-cycle reload.
  assign w_next_tx     = r_hold_full ? r_hold : FILL;
  assign w_rx_next     = {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};
  assign w_cs_unused   = w_cs_level ^ w_sclk_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_byte_done <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      if (w_load_accept)  r_hold      <= txData;
      if (w_load_accept)  r_hold_full <= 1'b1;
      else if (w_consume) r_hold_full <= 1'b0;

      if (w_start) begin
        r_tx_shift  <= w_next_tx;
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
      end else if (w_stop) begin
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b1;
            r_rx_data   <= w_rx_next;
            r_rx_valid  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        // The falling edge after a full byte starts the next tx byte.
        if (w_advance) begin
          if (r_byte_done) begin
            r_tx_shift  <= w_next_tx;
            r_byte_done <= 1'b0;
          end else begin
            r_tx_shift <= r_tx_shift >> 1;
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_TRISTATE_EN
  assign MISO = (r_state == SHIFT) ? r_tx_shift[0] : 1'bz;
`else
  assign MISO = (r_state == SHIFT) & r_tx_shift[0];
`endif

  assign txReady = !r_hold_full;
  assign rxData  = r_rx_data;
  assign rxValid = r_rx_valid;
  assign busy    = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-byte frames plus hand-written
// back-to-back, aborted-frame, mid-frame-reset and ignored-load sequences.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 4;

`ifdef SPI_SLAVE_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, SCLK, CS, MOSI, MISO;
  logic [7:0] txData, rxData;
  logic       txLoad, txReady, rxValid, busy;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .txData(txData), .txLoad(txLoad), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Every rxValid pulse is logged with the byte it carried.
  int         rv_count = 0;
  logic [7:0] rv_log [0:63];
  always @(negedge clk) begin
    if (rxValid === 1'b1) begin
      if (rv_count < 64) rv_log[rv_count] = rxData;
      rv_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    txData = d;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
  endtask

  task automatic cs_assert();
    @(negedge clk);
    CS = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_release();
    tick(HALF);
    CS = 1'b1;
    tick(6);
  endtask

  // Master side: drive MOSI in the low phase, sample MISO on the rising edge.
  task automatic send_bits(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_b[i];
      tick(HALF);
      SCLK = 1'b1;
      miso_b[i] = MISO;
      tick(HALF);
      SCLK = 1'b0;
    end
  endtask

  typedef struct {
    logic       pre_en;
    logic [7:0] pre;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs [5];

  task automatic run_frame(input vec_t v, input string tag);
    int         start;
    logic [7:0] got;
    if (v.pre_en) tx_write(v.pre);
    start = rv_count;
    cs_assert();
    send_bits(v.mosi, 8, got);
    cs_release();
    check({tag, " rxValid pulses"}, rv_count - start, 1);
    check({tag, " rxData"}, rxData, v.mosi);
    check({tag, " master rx"}, got, v.exp_miso);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         start;
    logic [7:0] m1, m2;

    vecs[0] = '{1'b1, 8'b00001001, 8'b01010011, 8'b00001001};
    vecs[1] = '{1'b0, 8'h00,       8'b00111100, 8'b00000000};
    vecs[2] = '{1'b1, 8'hA5,       8'h0F,       8'hA5};
    vecs[3] = '{1'b1, 8'h80,       8'hFF,       8'h80};
    vecs[4] = '{1'b1, 8'h01,       8'h00,       8'h01};

    reset = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    txLoad = 1'b0; txData = 8'h00;
    tick(2);
    check("reset MISO",    MISO,    MISO_IDLE);
    check("reset rxData",  rxData,  8'h00);
    check("reset rxValid", rxValid, 1'b0);
    check("reset txReady", txReady, 1'b1);
    check("reset busy",    busy,    1'b0);
    reset = 1'b1;
    tick(3);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d busy after", i), busy, 1'b0);
      check($sformatf("vec%0d txReady after", i), txReady, 1'b1);
    end

    // Back-to-back bytes in one select, second byte queued after first reload.
    tx_write(8'hFF);
    check("b2b txReady full", txReady, 1'b0);
    start = rv_count;
    cs_assert();
    check("b2b busy", busy, 1'b1);
    check("b2b txReady after reload", txReady, 1'b1);
    tx_write(8'b10011000);
    send_bits(8'b01010101, 8, m1);
    send_bits(8'b01011111, 8, m2);
    cs_release();
    check("b2b rxValid pulses", rv_count - start, 2);
    check("b2b rx byte0", rv_log[start],     8'b01010101);
    check("b2b rx byte1", rv_log[start + 1], 8'b01011111);
    check("b2b master byte0", m1, 8'b11111111);
    check("b2b master byte1", m2, 8'b10011000);

    // Aborted frame after 5 bits.
    start = rv_count;
    cs_assert();
    send_bits(8'h1F, 5, m1);
    check("abort busy mid", busy, 1'b1);
    cs_release();
    check("abort rxValid pulses", rv_count - start, 0);
    check("abort busy", busy, 1'b0);
    run_frame('{1'b1, 8'hC3, 8'h96, 8'hC3}, "after abort");

    // Asynchronous reset three bits into a frame.
    tx_write(8'h3C);
    cs_assert();
    send_bits(8'hE7, 3, m1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset MISO",    MISO,    MISO_IDLE);
    check("midreset rxData",  rxData,  8'h00);
    check("midreset rxValid", rxValid, 1'b0);
    check("midreset txReady", txReady, 1'b1);
    check("midreset busy",    busy,    1'b0);
    CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
    run_frame('{1'b1, 8'h6A, 8'hB4, 8'h6A}, "after reset");

    // Load while full is dropped.
    tx_write(8'h55);
    check("ignore txReady full", txReady, 1'b0);
    tx_write(8'hAA);
    check("ignore txReady still", txReady, 1'b0);
    run_frame('{1'b0, 8'h00, 8'h81, 8'h55}, "ignored load");
    check("ignore txReady after", txReady, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
